// File: rtl/dcache_pkg.sv
// Shared definitions for the L1 data cache controller.
// Holds the default geometry, the address-split widths derived from it,
// the bus widths and the controller FSM state encoding.
package dcache_pkg;

  localparam int NUM_LINES_DEF  = 64;
  localparam int LINE_WORDS_DEF = 4;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  localparam int OFFSET_W = $clog2(LINE_WORDS_DEF);
  localparam int INDEX_W  = $clog2(NUM_LINES_DEF);
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W - 2;

  typedef enum logic [2:0] {
    IDLE,
    REFILL_REQ,
    REFILL_WAIT,
    WRITE_REQ,
    WRITE_WAIT
  } state_e;

endpackage

// File: rtl/dcache_if.sv
// Bundle of the core-side request/response channel and the memory-side
// request/response channel of the data cache.
//   slave  : view of the cache controller (serves core, masters memory bus)
//   master : view of the surrounding system (core + memory)
// Core side  : req_valid_i, req_we_i, addr_i, write_en_i, wdata_i -> cache;
//              rdata_o, rsp_valid_o, stall_o <- cache
// Memory side: mem_req_valid_o, mem_req_we_o, mem_addr_o, mem_wdata_o,
//              mem_wstrb_o <- cache; mem_req_ready_i, mem_rsp_valid_i,
//              mem_rdata_i -> cache
interface dcache_if
  import dcache_pkg::*;
  ;
  logic              req_valid_i;
  logic              req_we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [STRB_W-1:0] write_en_i;
  logic [DATA_W-1:0] wdata_i;
  logic [DATA_W-1:0] rdata_o;
  logic              rsp_valid_o;
  logic              stall_o;

  logic              mem_req_valid_o;
  logic              mem_req_ready_i;
  logic              mem_req_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [STRB_W-1:0] mem_wstrb_o;
  logic              mem_rsp_valid_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i, addr_i, write_en_i, wdata_i,
    output rdata_o, rsp_valid_o, stall_o,
    output mem_req_valid_o, mem_req_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    input  mem_req_ready_i, mem_rsp_valid_i, mem_rdata_i
  );

  modport master (
    output req_valid_i, req_we_i, addr_i, write_en_i, wdata_i,
    input  rdata_o, rsp_valid_o, stall_o,
    input  mem_req_valid_o, mem_req_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    output mem_req_ready_i, mem_rsp_valid_i, mem_rdata_i
  );

endinterface

// File: rtl/dcache_data_ram.sv
// Cache data array: DEPTH x 32-bit single-port synchronous RAM with byte
// write enables. Read data appears the cycle after the address.
//   clk_i : clock
//   addr  : word address {index, offset}
//   be    : byte write enables (0000 = read only)
//   wdata : write data
//   rdata : registered read data (old contents on a write cycle)
module dcache_data_ram
  import dcache_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic [AW-1:0]     addr,
  input  logic [STRB_W-1:0] be,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < STRB_W; b++) begin
      if (be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache.
// Read hits answer the next cycle from the synchronous data RAM; read misses
// refill the whole line one word at a time; every store is written through
// to memory (and into the line too when it hits).
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : core request/response and memory request/response
//                  channels (dcache_if.slave)
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int NUM_LINES  = NUM_LINES_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic     clk_i,
  input  logic     rst_i,
  dcache_if.slave  bus
);

  // Geometry derived from the instance parameters (the package widths
  // describe the default geometry only).
  localparam int OFS_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TG_W   = ADDR_W - IDX_W - OFS_W - 2;
  localparam int RAM_AW = IDX_W + OFS_W;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * 4 - 1);

  state_e            state;
  logic [OFS_W-1:0]  cnt_q;
  logic [OFS_W-1:0]  off_q;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] cap_q;
  logic [DATA_W-1:0] rdata_q;
  logic              hit_vld_p1;
  logic [NUM_LINES-1:0] valid_q;
  logic [TG_W-1:0]   tag_q [NUM_LINES];

  logic [OFS_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_idx;
  logic [TG_W-1:0]   req_tag;
  logic [IDX_W-1:0]  fill_idx;
  logic [TG_W-1:0]   fill_tag;
  logic [OFS_W-1:0]  cnt_nxt;
  logic              hit;
  logic              last_beat;
  logic              fill_beat;
  logic [DATA_W-1:0] fill_word;

  logic [RAM_AW-1:0] ram_addr;
  logic [STRB_W-1:0] ram_be;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  assign req_off   = bus.addr_i[OFS_W+1:2];
  assign req_idx   = bus.addr_i[OFS_W+2 +: IDX_W];
  assign req_tag   = bus.addr_i[ADDR_W-1 -: TG_W];
  assign fill_idx  = base_q[OFS_W+2 +: IDX_W];
  assign fill_tag  = base_q[ADDR_W-1 -: TG_W];
  assign cnt_nxt   = cnt_q + OFS_W'(1);
  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign last_beat = (cnt_q == OFS_W'(LINE_WORDS - 1));
  assign fill_beat = (state == REFILL_WAIT) && bus.mem_rsp_valid_i;
  // The requested word may be the one arriving on the last beat itself.
  assign fill_word = (cnt_q == off_q) ? bus.mem_rdata_i : cap_q;

  // Single RAM port: core address in IDLE, refill slot otherwise.
  always_comb begin
    ram_addr  = {req_idx, req_off};
    ram_be    = '0;
    ram_wdata = bus.wdata_i;
    if (state != IDLE) ram_addr = {fill_idx, cnt_q};
    if (fill_beat) begin
      ram_be    = '1;
      ram_wdata = bus.mem_rdata_i;
    end else if ((state == IDLE) && bus.req_valid_i && bus.req_we_i && hit) begin
      ram_be    = bus.write_en_i;
    end
  end

  dcache_data_ram #(
    .DEPTH (NUM_LINES * LINE_WORDS),
    .AW    (RAM_AW)
  ) u_data_ram (
    .clk_i (clk_i),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign bus.stall_o = (state != IDLE);
  // Hit data comes straight off the RAM in the response cycle, then is held.
  assign bus.rdata_o = hit_vld_p1 ? ram_rdata : rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state               <= IDLE;
      valid_q             <= '0;
      hit_vld_p1          <= 1'b0;
      rdata_q             <= '0;
      bus.rsp_valid_o     <= 1'b0;
      bus.mem_req_valid_o <= 1'b0;
      bus.mem_req_we_o    <= 1'b0;
      bus.mem_addr_o      <= '0;
      bus.mem_wdata_o     <= '0;
      bus.mem_wstrb_o     <= '0;
    end else begin
      bus.rsp_valid_o <= 1'b0;
      hit_vld_p1      <= 1'b0;
      if (hit_vld_p1) rdata_q <= ram_rdata;
      unique case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            if (bus.req_we_i) begin
              state               <= WRITE_REQ;
              bus.mem_req_valid_o <= 1'b1;
              bus.mem_req_we_o    <= 1'b1;
              bus.mem_addr_o      <= bus.addr_i & ~ADDR_W'(3);
              bus.mem_wdata_o     <= bus.wdata_i;
              bus.mem_wstrb_o     <= bus.write_en_i;
            end else if (hit) begin
              bus.rsp_valid_o     <= 1'b1;
              hit_vld_p1          <= 1'b1;
            end else begin
              state               <= REFILL_REQ;
              cnt_q               <= '0;
              off_q               <= req_off;
              base_q              <= bus.addr_i & ~LINE_MASK;
              bus.mem_req_valid_o <= 1'b1;
              bus.mem_req_we_o    <= 1'b0;
              bus.mem_addr_o      <= bus.addr_i & ~LINE_MASK;
            end
          end
        end
        REFILL_REQ, WRITE_REQ: begin
          if (bus.mem_req_ready_i) begin
            state               <= (state == REFILL_REQ) ? REFILL_WAIT : WRITE_WAIT;
            bus.mem_req_valid_o <= 1'b0;
            bus.mem_req_we_o    <= 1'b0;
            bus.mem_addr_o      <= '0;
            bus.mem_wdata_o     <= '0;
            bus.mem_wstrb_o     <= '0;
          end
        end
        REFILL_WAIT: begin
          if (bus.mem_rsp_valid_i) begin
            if (cnt_q == off_q) cap_q <= bus.mem_rdata_i;
            if (last_beat) begin
              // Line only becomes valid once every word is in the RAM.
              valid_q[fill_idx] <= 1'b1;
              tag_q[fill_idx]   <= fill_tag;
              rdata_q           <= fill_word;
              bus.rsp_valid_o   <= 1'b1;
              state             <= IDLE;
            end else begin
              cnt_q               <= cnt_nxt;
              state               <= REFILL_REQ;
              bus.mem_req_valid_o <= 1'b1;
              bus.mem_addr_o      <= base_q | ADDR_W'({cnt_nxt, 2'b00});
            end
          end
        end
        WRITE_WAIT: begin
          if (bus.mem_rsp_valid_i) begin
            bus.rsp_valid_o <= 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
module tb_dcache_controller;
  import dcache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_if bus_if ();

  dcache_controller #(
    .NUM_LINES  (64),
    .LINE_WORDS (4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] rdata;
    bit          is_load;
    int          due;
    string       tag;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } bus_t;
  bus_t bus_log[$];

  logic [31:0] mem_model [logic [31:0]];
  bit          pending    = 0;
  logic [31:0] pend_data  = '0;
  bit          stray      = 0;
  bit          hold_armed = 0;
  bit          hold_first = 0;
  bit          hold_now   = 0;
  int          hold_left  = 0;
  logic [31:0] hold_addr  = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return 32'hA5A5_0000 | {16'h0, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model: responds one cycle after accepting a request.
  always @(negedge clk) begin
    bus_if.mem_rsp_valid_i = 1'b0;
    bus_if.mem_rdata_i     = '0;
    if (pending || stray) begin
      bus_if.mem_rsp_valid_i = 1'b1;
      bus_if.mem_rdata_i     = stray ? 32'hDEAD_BEEF : pend_data;
      pending = 0;
      stray   = 0;
    end
    bus_if.mem_req_ready_i = 1'b1;
    if (!bus_if.mem_req_valid_o) begin
      if (!rst)
        chk("idle_payload", bus_if.mem_addr_o | bus_if.mem_wdata_o |
            {28'h0, bus_if.mem_wstrb_o} | {31'h0, bus_if.mem_req_we_o}, 32'h0);
    end else begin
      hold_now = hold_armed && !bus_if.mem_req_we_o && (bus_if.mem_addr_o[3:2] == 2'd2);
      if (hold_now && hold_first) begin
        hold_addr  = bus_if.mem_addr_o;
        hold_first = 0;
      end else if (hold_now) begin
        chk("hold_stable_addr", bus_if.mem_addr_o, hold_addr);
      end
      if (hold_now && hold_left > 0) begin
        bus_if.mem_req_ready_i = 1'b0;
        hold_left--;
      end else begin
        if (hold_now) hold_armed = 0;
        bus_log.push_back(bus_t'{we: bus_if.mem_req_we_o, addr: bus_if.mem_addr_o,
                                 wdata: bus_if.mem_wdata_o, strb: bus_if.mem_wstrb_o});
        if (bus_if.mem_req_we_o) begin
          logic [31:0] w;
          w = mem_word(bus_if.mem_addr_o);
          for (int b = 0; b < 4; b++)
            if (bus_if.mem_wstrb_o[b]) w[8*b +: 8] = bus_if.mem_wdata_o[8*b +: 8];
          mem_model[bus_if.mem_addr_o] = w;
          pend_data = '0;
        end else begin
          pend_data = mem_word(bus_if.mem_addr_o);
        end
        pending = 1;
      end
    end
  end

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus_if.rsp_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_rsp_cycle"}, cyc, e.due);
        if (e.is_load) chk({e.tag, "_rdata"}, bus_if.rdata_o, e.rdata);
      end
    end
  endtask

  task automatic issue(input string tag, input bit we, input logic [31:0] addr,
                       input logic [3:0] en, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input int lat, input bit track);
    chk({tag, "_not_stalled"}, {31'h0, bus_if.stall_o}, 32'd0);
    bus_if.req_valid_i = 1'b1;
    bus_if.req_we_i    = we;
    bus_if.addr_i      = addr;
    bus_if.write_en_i  = en;
    bus_if.wdata_i     = wd;
    if (track) sb.push_back(exp_t'{rdata: exp_rd, is_load: !we, due: cyc + lat, tag: tag});
    step();
    bus_if.req_valid_i = 1'b0;
    bus_if.req_we_i    = 1'b0;
    bus_if.addr_i      = '0;
    bus_if.write_en_i  = '0;
    bus_if.wdata_i     = '0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && sb.size() > 0; i++) step();
    chk({tag, "_drained"}, sb.size(), 32'd0);
    sb.delete();
    chk({tag, "_idle"}, {31'h0, bus_if.stall_o}, 32'd0);
  endtask

  task automatic check_log(input string tag, input int n, input bit we,
                           input logic [31:0] a0, input logic [31:0] wd, input logic [3:0] st);
    chk({tag, "_bus_count"}, bus_log.size(), n);
    for (int i = 0; i < n && i < bus_log.size(); i++) begin
      chk({tag, "_bus_addr"}, bus_log[i].addr, a0 + 32'(4 * i));
      chk({tag, "_bus_we"}, {31'h0, bus_log[i].we}, {31'h0, we});
      if (we) begin
        chk({tag, "_bus_wdata"}, bus_log[i].wdata, wd);
        chk({tag, "_bus_wstrb"}, {28'h0, bus_log[i].strb}, {28'h0, st});
      end
    end
    bus_log.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_stall"},     {31'h0, bus_if.stall_o},         32'd0);
    chk({tag, "_rsp_valid"}, {31'h0, bus_if.rsp_valid_o},     32'd0);
    chk({tag, "_rdata"},     bus_if.rdata_o,                  32'd0);
    chk({tag, "_mem_valid"}, {31'h0, bus_if.mem_req_valid_o}, 32'd0);
    chk({tag, "_mem_we"},    {31'h0, bus_if.mem_req_we_o},    32'd0);
    chk({tag, "_mem_addr"},  bus_if.mem_addr_o,               32'd0);
    chk({tag, "_mem_wdata"}, bus_if.mem_wdata_o,              32'd0);
    chk({tag, "_mem_wstrb"}, {28'h0, bus_if.mem_wstrb_o},     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.req_valid_i = 1'b0;
    bus_if.req_we_i    = 1'b0;
    bus_if.addr_i      = '0;
    bus_if.write_en_i  = '0;
    bus_if.wdata_i     = '0;
    bus_if.mem_req_ready_i = 1'b1;
    bus_if.mem_rsp_valid_i = 1'b0;
    bus_if.mem_rdata_i     = '0;
    rst = 1'b1;
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Cold read miss, then a hit one cycle after the response.
    issue("cold_rd", 0, 32'h0000_0104, 4'h0, 32'h0, 32'hA5A5_0104, 9, 1);
    drain("cold_rd");
    check_log("cold_rd", 4, 0, 32'h0000_0100, 32'h0, 4'h0);
    step();
    issue("hit_rd", 0, 32'h0000_0104, 4'h0, 32'h0, 32'hA5A5_0104, 1, 1);
    drain("hit_rd");
    check_log("hit_rd", 0, 0, 32'h0, 32'h0, 4'h0);

    // Store hit with partial strobes, then back-to-back read of the word.
    issue("st_hit", 1, 32'h0000_0106, 4'b1100, 32'hBEEF_BEEF, 32'h0, 3, 1);
    drain("st_hit");
    check_log("st_hit", 1, 1, 32'h0000_0104, 32'hBEEF_BEEF, 4'b1100);
    issue("rd_after_st", 0, 32'h0000_0104, 4'h0, 32'h0, 32'hBEEF_0104, 1, 1);
    drain("rd_after_st");
    check_log("rd_after_st", 0, 0, 32'h0, 32'h0, 4'h0);

    // Store miss: write-through only, the later read refills.
    issue("st_miss", 1, 32'h0000_2000, 4'hF, 32'h1234_5678, 32'h0, 3, 1);
    drain("st_miss");
    check_log("st_miss", 1, 1, 32'h0000_2000, 32'h1234_5678, 4'hF);
    issue("rd_2000", 0, 32'h0000_2000, 4'h0, 32'h0, 32'h1234_5678, 9, 1);
    drain("rd_2000");
    check_log("rd_2000", 4, 0, 32'h0000_2000, 32'h0, 4'h0);

    // Conflict on index 0x10.
    issue("rd_100", 0, 32'h0000_0100, 4'h0, 32'h0, 32'hA5A5_0100, 1, 1);
    drain("rd_100");
    check_log("rd_100", 0, 0, 32'h0, 32'h0, 4'h0);
    issue("rd_500", 0, 32'h0000_0500, 4'h0, 32'h0, 32'hA5A5_0500, 9, 1);
    drain("rd_500");
    check_log("rd_500", 4, 0, 32'h0000_0500, 32'h0, 4'h0);
    issue("rd_100_again", 0, 32'h0000_0100, 4'h0, 32'h0, 32'hA5A5_0100, 9, 1);
    drain("rd_100_again");
    check_log("rd_100_again", 4, 0, 32'h0000_0100, 32'h0, 4'h0);

    // Ready held low for 3 cycles on beat 2.
    hold_left  = 3;
    hold_first = 1;
    hold_armed = 1;
    issue("rd_hold", 0, 32'h0000_3008, 4'h0, 32'h0, 32'hA5A5_3008, 12, 1);
    drain("rd_hold");
    check_log("rd_hold", 4, 0, 32'h0000_3000, 32'h0, 4'h0);
    chk("hold_consumed", {31'h0, hold_armed}, 32'd0);

    // Store with no byte enables still goes to the bus.
    issue("st_zero", 1, 32'h0000_3004, 4'h0, 32'hFFFF_FFFF, 32'h0, 3, 1);
    drain("st_zero");
    check_log("st_zero", 1, 1, 32'h0000_3004, 32'hFFFF_FFFF, 4'h0);
    issue("rd_3004", 0, 32'h0000_3004, 4'h0, 32'h0, 32'hA5A5_3004, 1, 1);
    drain("rd_3004");

    // Reset in the middle of a refill.
    issue("rd_abort", 0, 32'h0000_4000, 4'h0, 32'h0, 32'h0, 9, 0);
    for (int i = 0; i < 50; i++) begin
      if (bus_log.size() >= 2 && bus_if.stall_o && !bus_if.mem_req_valid_o) break;
      step();
    end
    chk("abort_in_wait", {31'h0, (bus_if.stall_o && !bus_if.mem_req_valid_o)}, 32'd1);
    rst = 1'b1;
    step();
    check_reset_outputs("mid_reset");
    rst   = 1'b0;
    stray = 1;
    step();
    chk("stray_no_rsp",   {31'h0, bus_if.rsp_valid_o}, 32'd0);
    chk("stray_no_stall", {31'h0, bus_if.stall_o},     32'd0);
    step();
    chk("stray_no_rsp2",  {31'h0, bus_if.rsp_valid_o}, 32'd0);
    bus_log.delete();
    issue("rd_after_rst", 0, 32'h0000_4000, 4'h0, 32'h0, 32'hA5A5_4000, 9, 1);
    drain("rd_after_rst");
    check_log("rd_after_rst", 4, 0, 32'h0000_4000, 32'h0, 4'h0);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
